pwm_breathe_multi: RTL and testbench

//  Multi-channel PWM LED driver, parametrised successor of the single-channel breathing PWM top.

---
 rtl/pwm_breathe_pkg.sv | 50 +++++
 rtl/pwm_breathe_sine_rom.sv | 29 ++
 rtl/pwm_breathe_multi.sv | 185 ++++++++++++++++++
 tb/tb_pwm_breathe_multi.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_breathe_pkg.sv
// Shared definitions for the multi-channel breathing PWM driver:
// mode codes, config register addresses and the sine sample generator.
package pwm_breathe_pkg;

  localparam logic [1:0] MODE_OFF     = 2'd0;
  localparam logic [1:0] MODE_STATIC  = 2'd1;
  localparam logic [1:0] MODE_BREATHE = 2'd2;

  localparam logic [1:0] ADDR_MODE    = 2'd0;
  localparam logic [1:0] ADDR_DUTY    = 2'd1;
  localparam logic [1:0] ADDR_PHASE   = 2'd2;
  localparam logic [1:0] ADDR_SPEED   = 2'd3;

  localparam logic [7:0] SPEED_RESET  = 8'd63;

  // round((2**pwm_w-1) * (1-cos(2*pi*k/depth))/2), evaluated at elaboration.
  // Uses the identity (1-cos(2a))/2 = sin(a)**2 with a = pi*k/depth, folded
  // into [0, pi/2], and a Q30 Taylor series. A tiny positive bias makes the
  // exact .5 cases (k = depth/4, 3*depth/4) round up consistently.
  function automatic int sine_sample(input int k, input int pwm_w, input int depth);
    longint pi_q;
    longint x;
    longint x2;
    longint term;
    longint sum;
    longint sq;
    longint val;
    int     j;
    pi_q = 64'sd3373259426;
    j    = k;
    if (32'sd2 * j > depth) begin
      j = depth - j;
    end else begin
      j = k;
    end
    x    = (pi_q * longint'(j)) / longint'(depth);
    x2   = (x * x) / 64'sd1073741824;
    term = x;
    sum  = x;
    for (int n = 1; n <= 8; n++) begin
      term = (term * x2) / 64'sd1073741824;
      term = -term / longint'((32'sd2 * n) * (32'sd2 * n + 32'sd1));
      sum  = sum + term;
    end
    sq  = (sum * sum) / 64'sd1073741824;
    val = longint'((32'sd1 << pwm_w) - 32'sd1) * sq;
    return int'((val + 64'sd536870912 + 64'sd1024) / 64'sd1073741824);
  endfunction

endpackage

// File: rtl/pwm_breathe_sine_rom.sv
// Combinational sine lookup: one breathe-cycle sample per address.
// Entries past LUT_DEPTH read as zero; the table is fixed at elaboration.
module pwm_breathe_sine_rom #(
  parameter int PWM_W     = 6,
  parameter int LUT_DEPTH = 100,
  parameter int IDX_W     = 7
) (
  input  logic [IDX_W-1:0] addr_i,
  output logic [PWM_W-1:0] sample_o
);
  import pwm_breathe_pkg::*;

  logic [PWM_W-1:0] table_s [2**IDX_W];

  for (genvar k = 0; k < 2**IDX_W; k++) begin : g_tab
    if (k < LUT_DEPTH) begin : g_live
      localparam logic [PWM_W-1:0] SAMPLE = PWM_W'(sine_sample(k, PWM_W, LUT_DEPTH));
      assign table_s[k] = SAMPLE;
    end else begin : g_pad
      assign table_s[k] = '0;
    end
  end

  // Address decode into the constant table.
  always_comb begin
    sample_o = table_s[addr_i];
  end

endmodule

// File: rtl/pwm_breathe_multi.sv
// Multi-channel PWM LED driver with shared counter and breathe-rate divider.
// Per-channel mode/duty/phase are written into shadow registers and become
// active only at the PWM period boundary, so no period is ever cut short.
module pwm_breathe_multi #(
  parameter int  CHANNELS  = 4,
  parameter int  PWM_W     = 6,
  parameter int  LUT_DEPTH = 100,
  parameter int  IDX_W     = 7,
  parameter int  DIV_W     = 10,
  parameter int  DIV_SCALE = 10,
  // One spare code so that out-of-range channels can be addressed and flagged.
  localparam int CHAN_W    = $clog2(CHANNELS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CHAN_W-1:0]   cfg_chan,
  input  logic [1:0]          cfg_addr,
  input  logic [7:0]          cfg_data,
  output logic                cfg_err,
  output logic [CHANNELS-1:0] pwm_o,
  output logic                period_o
);
  import pwm_breathe_pkg::*;

  localparam logic [PWM_W-1:0] CNT_MAX  = '1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LUT_DEPTH - 1);
  localparam logic [IDX_W:0]   DEPTH_X  = (IDX_W + 1)'(LUT_DEPTH);

  logic [PWM_W-1:0]    cnt_q, cnt_d;
  logic [DIV_W-1:0]    tick_cnt_q, tick_cnt_d, div_lim_s;
  logic [7:0]          speed_q, speed_d;
  logic [IDX_W-1:0]    index_q, index_d;
  logic                tick_s, wrap_s, accept_s, chan_ok_s, period_d, err_d;
  logic [IDX_W-1:0]    phase_wr_s;
  logic [1:0]          sh_mode_q  [CHANNELS];
  logic [1:0]          sh_mode_d  [CHANNELS];
  logic [1:0]          act_mode_q [CHANNELS];
  logic [1:0]          act_mode_d [CHANNELS];
  logic [PWM_W-1:0]    sh_duty_q  [CHANNELS];
  logic [PWM_W-1:0]    sh_duty_d  [CHANNELS];
  logic [PWM_W-1:0]    act_duty_q [CHANNELS];
  logic [PWM_W-1:0]    act_duty_d [CHANNELS];
  logic [IDX_W-1:0]    sh_phase_q [CHANNELS];
  logic [IDX_W-1:0]    sh_phase_d [CHANNELS];
  logic [IDX_W-1:0]    act_phase_q[CHANNELS];
  logic [IDX_W-1:0]    act_phase_d[CHANNELS];
  logic [IDX_W-1:0]    rom_addr_s [CHANNELS];
  logic [PWM_W-1:0]    rom_data_s [CHANNELS];
  logic [PWM_W-1:0]    level_q    [CHANNELS];
  logic [PWM_W-1:0]    level_d    [CHANNELS];
  logic [CHANNELS-1:0] pwm_d;

  // Next state for counter, divider, breathe index and the config registers.
  always_comb begin
    accept_s   = cfg_valid & cfg_ready;
    chan_ok_s  = (cfg_chan < CHAN_W'(CHANNELS));
    wrap_s     = (cnt_q == CNT_MAX);
    cnt_d      = cnt_q + PWM_W'(1);
    period_d   = (cnt_q == '0);
    err_d      = accept_s & (cfg_addr != ADDR_SPEED) & ~chan_ok_s;
    div_lim_s  = DIV_W'(32'(DIV_SCALE) * 32'(speed_q));
    tick_s     = (speed_q != 8'd0) && (tick_cnt_q >= div_lim_s);
    tick_cnt_d = tick_s ? '0 : tick_cnt_q + DIV_W'(1);
    phase_wr_s = IDX_W'(32'(cfg_data) % 32'(LUT_DEPTH));
    if (tick_s) begin
      index_d = (index_q == IDX_LAST) ? '0 : index_q + IDX_W'(1);
    end else begin
      index_d = index_q;
    end
    if (accept_s && (cfg_addr == ADDR_SPEED)) begin
      speed_d = cfg_data;
    end else begin
      speed_d = speed_q;
    end
    for (int c = 0; c < CHANNELS; c++) begin
      sh_mode_d[c]  = sh_mode_q[c];
      sh_duty_d[c]  = sh_duty_q[c];
      sh_phase_d[c] = sh_phase_q[c];
      if (accept_s && chan_ok_s && (cfg_chan == CHAN_W'(c))) begin
        case (cfg_addr)
          ADDR_MODE:  sh_mode_d[c]  = cfg_data[1:0];
          ADDR_DUTY:  sh_duty_d[c]  = cfg_data[PWM_W-1:0];
          ADDR_PHASE: sh_phase_d[c] = phase_wr_s;
          default:    sh_mode_d[c]  = sh_mode_q[c];
        endcase
      end else begin
        sh_mode_d[c] = sh_mode_q[c];
      end
      // Shadow values from before this edge go live, so a write on the
      // wrap cycle itself waits one more period.
      if (wrap_s) begin
        act_mode_d[c]  = sh_mode_q[c];
        act_duty_d[c]  = sh_duty_q[c];
        act_phase_d[c] = sh_phase_q[c];
      end else begin
        act_mode_d[c]  = act_mode_q[c];
        act_duty_d[c]  = act_duty_q[c];
        act_phase_d[c] = act_phase_q[c];
      end
    end
  end

  // Per-channel sine address from the upcoming index and phase, mod LUT_DEPTH.
  always_comb begin
    logic [IDX_W:0] sum_v;
    sum_v = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      sum_v = {1'b0, index_d} + {1'b0, act_phase_d[c]};
      if (sum_v >= DEPTH_X) begin
        rom_addr_s[c] = IDX_W'(sum_v - DEPTH_X);
      end else begin
        rom_addr_s[c] = sum_v[IDX_W-1:0];
      end
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_rom
    pwm_breathe_sine_rom #(
      .PWM_W    (PWM_W),
      .LUT_DEPTH(LUT_DEPTH),
      .IDX_W    (IDX_W)
    ) u_rom (
      .addr_i  (rom_addr_s[c]),
      .sample_o(rom_data_s[c])
    );
  end

  // Level selection per mode and the registered compare against the counter.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      case (act_mode_d[c])
        MODE_STATIC:  level_d[c] = act_duty_d[c];
        MODE_BREATHE: level_d[c] = rom_data_s[c];
        default:      level_d[c] = '0;
      endcase
      pwm_d[c] = en & ((act_mode_q[c] == MODE_STATIC) | (act_mode_q[c] == MODE_BREATHE))
                    & (cnt_q < level_q[c]);
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      tick_cnt_q <= '0;
      speed_q    <= SPEED_RESET;
      index_q    <= '0;
      cfg_ready  <= 1'b0;
      cfg_err    <= 1'b0;
      period_o   <= 1'b0;
      pwm_o      <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        sh_mode_q[c]   <= MODE_OFF;
        act_mode_q[c]  <= MODE_OFF;
        sh_duty_q[c]   <= '0;
        act_duty_q[c]  <= '0;
        sh_phase_q[c]  <= '0;
        act_phase_q[c] <= '0;
        level_q[c]     <= '0;
      end
    end else begin
      cnt_q      <= cnt_d;
      tick_cnt_q <= tick_cnt_d;
      speed_q    <= speed_d;
      index_q    <= index_d;
      cfg_ready  <= 1'b1;
      cfg_err    <= err_d;
      period_o   <= period_d;
      pwm_o      <= pwm_d;
      for (int c = 0; c < CHANNELS; c++) begin
        sh_mode_q[c]   <= sh_mode_d[c];
        act_mode_q[c]  <= act_mode_d[c];
        sh_duty_q[c]   <= sh_duty_d[c];
        act_duty_q[c]  <= act_duty_d[c];
        sh_phase_q[c]  <= sh_phase_d[c];
        act_phase_q[c] <= act_phase_d[c];
        level_q[c]     <= level_d[c];
      end
    end
  end

endmodule

// File: tb/tb_pwm_breathe_multi.sv
// Self-checking bench for pwm_breathe_multi: a per-cycle behavioural model
// plus directed scenarios with hand-computed expectations.
module tb_pwm_breathe_multi;

  logic       clk;
  logic       rst;
  logic       en;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [2:0] cfg_chan;
  logic [1:0] cfg_addr;
  logic [7:0] cfg_data;
  logic       cfg_err;
  logic [3:0] pwm_o;
  logic       period_o;

  int n_checks = 0;
  int n_pass   = 0;

  pwm_breathe_multi dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_chan (cfg_chan),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .cfg_err  (cfg_err),
    .pwm_o    (pwm_o),
    .period_o (period_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at t=%0t: got %0d, want %0d", name, $time, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  int   rom_tbl [100];
  int   m_cnt, m_tick, m_speed, m_index;
  int   sh_mode [4], sh_duty [4], sh_phase [4];
  int   ac_mode [4], ac_duty [4], ac_phase [4];
  logic [3:0] e_pwm;
  logic e_period, e_err, e_ready;
  bit   model_live = 1'b0;

  function automatic int level_of(input int c);
    if (ac_mode[c] == 1) return ac_duty[c];
    if (ac_mode[c] == 2) return rom_tbl[(m_index + (ac_phase[c] % 100)) % 100];
    return 0;
  endfunction

  always @(posedge clk) begin : model
    bit acc;
    bit tk;
    int lim;
    if (rst) begin
      m_cnt = 0; m_tick = 0; m_speed = 63; m_index = 0;
      for (int c = 0; c < 4; c++) begin
        sh_mode[c] = 0; sh_duty[c] = 0; sh_phase[c] = 0;
        ac_mode[c] = 0; ac_duty[c] = 0; ac_phase[c] = 0;
      end
      e_pwm = 4'd0; e_period = 1'b0; e_err = 1'b0; e_ready = 1'b0;
      model_live = 1'b1;
    end else begin
      acc      = cfg_valid && e_ready;
      e_period = (m_cnt == 0);
      for (int c = 0; c < 4; c++)
        e_pwm[c] = en && (ac_mode[c] == 1 || ac_mode[c] == 2) && (m_cnt < level_of(c));
      e_err    = acc && (cfg_addr != 2'd3) && (cfg_chan >= 3'd4);
      e_ready  = 1'b1;
      lim      = (10 * m_speed) % 1024;
      tk       = (m_speed != 0) && (m_tick >= lim);
      m_tick   = tk ? 0 : (m_tick + 1) % 1024;
      if (tk) m_index = (m_index + 1) % 100;
      if (m_cnt == 63) begin
        for (int c = 0; c < 4; c++) begin
          ac_mode[c] = sh_mode[c]; ac_duty[c] = sh_duty[c]; ac_phase[c] = sh_phase[c];
        end
      end
      if (acc) begin
        if (cfg_addr == 2'd3) m_speed = int'(cfg_data);
        else if (cfg_chan < 3'd4) begin
          if (cfg_addr == 2'd0) sh_mode[cfg_chan]  = int'(cfg_data) % 4;
          if (cfg_addr == 2'd1) sh_duty[cfg_chan]  = int'(cfg_data) % 64;
          if (cfg_addr == 2'd2) sh_phase[cfg_chan] = int'(cfg_data);
        end
      end
      m_cnt = (m_cnt + 1) % 64;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (model_live) begin
      chk("pwm_o",     32'(pwm_o),     32'(e_pwm));
      chk("period_o",  32'(period_o),  32'(e_period));
      chk("cfg_err",   32'(cfg_err),   32'(e_err));
      chk("cfg_ready", 32'(cfg_ready), 32'(e_ready));
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  task automatic write(input int ch, input int addr, input int data);
    cfg_valid = 1'b1;
    cfg_chan  = 3'(ch);
    cfg_addr  = 2'(addr);
    cfg_data  = 8'(data);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic wait_period();
    int i = 0;
    @(negedge clk);
    while (period_o !== 1'b1 && i < 200) begin
      @(negedge clk);
      i++;
    end
    if (period_o !== 1'b1) chk("period_timeout", 32'(period_o), 32'd1);
  endtask

  task automatic count_period(input int ch, output int n);
    n = int'(pwm_o[ch]);
    for (int i = 1; i < 64; i++) begin
      @(negedge clk);
      n += int'(pwm_o[ch]);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int n2;
    int cnt_a;
    int cnt_b;
    rst = 1'b1; en = 1'b1; cfg_valid = 1'b0;
    cfg_chan = 3'd0; cfg_addr = 2'd0; cfg_data = 8'd0;
    for (int k = 0; k < 100; k++)
      rom_tbl[k] = $rtoi(63.0 * (1.0 - $cos(2.0 * 3.141592653589793 * k / 100.0)) / 2.0 + 0.5 + 1.0e-6);
    chk("rom_k0",  32'(rom_tbl[0]),  32'd0);
    chk("rom_k10", 32'(rom_tbl[10]), 32'd6);
    chk("rom_k25", 32'(rom_tbl[25]), 32'd32);
    chk("rom_k50", 32'(rom_tbl[50]), 32'd63);

    repeat (3) @(negedge clk);
    chk("reset_ready", 32'(cfg_ready), 32'd0);
    chk("reset_pwm",   32'(pwm_o),     32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_cycle1", 32'(cfg_ready), 32'd1);

    // Idle: no writes, outputs stay low, one period pulse per 64 clk.
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      cnt_a += int'(|pwm_o);
      cnt_b += int'(period_o);
    end
    chk("idle_pwm_high", 32'(cnt_a), 32'd0);
    chk("idle_periods",  32'(cnt_b), 32'd16);

    // ch0 static duty sweep.
    wait_period(); write(0, 0, 1); write(0, 1, 16);
    wait_period(); count_period(0, n); chk("static_16", 32'(n), 32'd16);
    wait_period(); write(0, 1, 63);
    wait_period(); count_period(0, n); chk("static_63", 32'(n), 32'd63);
    wait_period(); write(0, 1, 0);
    wait_period(); count_period(0, n); chk("static_0", 32'(n), 32'd0);

    // ch1 duty change mid-period.
    wait_period(); write(1, 1, 10); write(1, 0, 1);
    wait_period();
    n = int'(pwm_o[1]);
    for (int i = 1; i < 64; i++) begin
      cfg_valid = (i == 20); cfg_chan = 3'd1; cfg_addr = 2'd1; cfg_data = 8'd40;
      @(negedge clk);
      n += int'(pwm_o[1]);
    end
    cfg_valid = 1'b0;
    chk("mid_write_old", 32'(n), 32'd10);
    wait_period(); count_period(1, n); chk("mid_write_new", 32'(n), 32'd40);

    // Invalid channel write.
    cfg_valid = 1'b1; cfg_chan = 3'd5; cfg_addr = 2'd1; cfg_data = 8'd33;
    @(negedge clk);
    cfg_valid = 1'b0;
    n = int'(cfg_err);
    repeat (3) begin @(negedge clk); n += int'(cfg_err); end
    chk("err_pulses", 32'(n), 32'd1);

    // Breathing with phase offsets; phase 150 must track phase 50.
    wait_period();
    write(4, 3, 1);
    write(0, 0, 2); write(0, 2, 0);
    write(1, 0, 2); write(1, 2, 150);
    write(2, 0, 2); write(2, 2, 50);
    wait_period();
    n = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      n += int'(pwm_o[1] != pwm_o[2]);
    end
    chk("phase150_eq_50", 32'(n), 32'd0);

    // speed 0 freezes the breathe level.
    write(4, 3, 0);
    wait_period(); wait_period(); count_period(0, n);
    wait_period(); count_period(0, n2);
    chk("frozen_level", 32'(n2), 32'(n));

    // Randomised traffic against the model.
    for (int it = 0; it < 300; it++) begin
      int a;
      repeat ($urandom_range(0, 80)) @(negedge clk);
      en = ($urandom_range(0, 9) != 0);
      a  = $urandom_range(0, 3);
      if (a == 3)      write($urandom_range(0, 7), a, $urandom_range(0, 3));
      else if (a == 0) write($urandom_range(0, 7), a, $urandom_range(0, 3));
      else             write($urandom_range(0, 7), a, $urandom_range(0, 255));
    end

    // Reset in the middle of breathing.
    en = 1'b1;
    write(0, 0, 2); write(4, 3, 1);
    repeat (300) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_pwm",    32'(pwm_o),     32'd0);
    chk("rst_mid_period", 32'(period_o),  32'd0);
    chk("rst_mid_ready",  32'(cfg_ready), 32'd0);
    rst = 1'b0;
    repeat (100) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
